gf180mcu_ef_io__gpio_bank_ctrl: RTL
===================================

// Module: gf180mcu_ef_io__gpio_bank_ctrl
// PURPOSE
//  NCH-channel controller for bank of gf180mcu bidirectional pad cells (bi_t style).
//  Holds per-pin config (OE, IE, PU, PD, CS, SL, PDRV0/1) behind a simple register port.
//  Synchronises pad Y inputs; latches rising-edge interrupts.
//  Enforces break-before-make on electrical reconfig; sits in core domain, pad side.
// PARAMETERS
//  NCH          8  channels, 1..32; also register data width
//  SYNC_STAGES  2  input synchroniser depth, >=2
//  SETTLE       4  cycles OE held low during reconfig, 1..15
// PORTS
//  CLK        in   1    clock, all logic rising-edge
//  RN         in   1    reset, synchronous, active-low
//  REG_VALID  in   1    access request
//  REG_WE     in   1    1=write, 0=read
//  REG_ADDR   in   4    word address (map below)
//  REG_WDATA  in   NCH  write data, bit i = channel i
//  REG_READY  out  1    access accepted this cycle when VALID&READY
//  REG_RDATA  out  NCH  read data, valid cycle after accepted read
//  PAD_Y      in   NCH  Y from pad cells (async)
//  PAD_A/OE/IE/PU/PD/CS/SL/PDRV0/PDRV1  out  NCH each  to pad cells
//  IRQ        out  1    registered |(PEND & IRQ_EN)
// BEHAVIOUR
//  Map: 0 OUT,1 OE,2 IE,3 PU,4 PD,5 CS,6 SL,7 DRV0,8 DRV1 (RW); 9 IN (RO sync value);
//   10 PEND (W1C); 11 IRQ_EN (RW); 12-15 read 0, writes ignored.
//  Reset (RN=0 at edge): all regs, pad outputs, PEND, IRQ, RDATA = 0; sync flops 0;
//   FSM=IDLE; REG_READY=1. Reset mid-BREAK aborts, all outputs 0 next cycle.
//  Writes to 0-4, 11 take effect on pad outputs 1 cycle after acceptance.
//  PAD_PU = PU & ~PD (pulldown wins if both set); PAD_PD = PD.
//  Reconfig (write to 5-8) FSM: IDLE -> BREAK -> APPLY -> IDLE.
//   IDLE: accept write, store in shadow; CH = channels whose value changes.
//    CH==0: no state change, READY stays 1.
//   BREAK: PAD_OE[i]=0 for i in CH, others unchanged; counts SETTLE cycles; READY=0.
//   APPLY: 1 cycle; shadow copied to PAD_CS/SL/PDRV; READY=0.
//   Next IDLE: PAD_OE restored from OE reg (incl. writes before the reconfig).
//  READY=0 stalls reads and writes; master holds VALID/ADDR/DATA until accepted.
//  Input: sync chain samples PAD_Y & PAD_IE; IE=0 forces IN=0, no edges.
//  PEND[i] set on sync 0->1 transition; cleared by write 1 to addr 10.
//   Set and W1C same cycle: set wins. Writes of 0 leave bits unchanged.
//  IRQ registered: rises 1 cycle after PEND&IRQ_EN nonzero.
//  Read latency 1: RDATA updates cycle after accepted read, else holds.
//  Unused upper address bits and NCH-truncated data ignored; no X on any output.
// TESTING
//  Reset: drive all regs nonzero, RN=0 1 cycle -> all pad outs, IRQ, RDATA=0, READY=1.
//  OE=0xFF, write DRV0=0x0F (SETTLE=4) -> PAD_OE=0xF0 4 cyc, READY=0 5 cyc, then
//   PAD_PDRV0=0x0F, PAD_OE=0xFF.
//  Write DRV0 with identical value -> no BREAK, READY never drops.
//  IE[3]=1, PAD_Y[3] 0->1 -> IN[3]=1 after 2 cyc, PEND=0x08; IRQ_EN=0x08 -> IRQ=1;
//   W1C 0x08 same cycle as new edge -> PEND stays 0x08.
//  PU=PD=0x01 -> PAD_PU[0]=0, PAD_PD[0]=1; IE=0 with Y=1 -> IN=0, no PEND.
//  RN=0 mid-BREAK -> FSM IDLE, PAD_OE=0, shadow discarded, READY=1 next cycle.

Source files
------------

// File: rtl/gf180mcu_ef_io__gpio_bank_ctrl_if.sv
// Register access port of the GPIO bank controller: single-beat valid/ready
// request with one-cycle read data return.
interface gf180mcu_ef_io__gpio_bank_ctrl_if #(
    parameter int NCH = 8
);
    logic           valid;
    logic           we;
    logic [3:0]     addr;
    logic [NCH-1:0] wdata;
    logic           ready;
    logic [NCH-1:0] rdata;

    modport master (
        output valid, we, addr, wdata,
        input  ready, rdata
    );

    modport slave (
        input  valid, we, addr, wdata,
        output ready, rdata
    );
endinterface

// File: rtl/gf180mcu_ef_io__gpio_bank_ctrl.sv
// Per-pin configuration, input synchronisation, edge interrupts and
// break-before-make sequencing for a bank of gf180mcu bidirectional pads.
module gf180mcu_ef_io__gpio_bank_ctrl #(
    parameter int NCH         = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 4
) (
    input  logic                clk_i,
    input  logic                rn_i,
    gf180mcu_ef_io__gpio_bank_ctrl_if.slave reg_if,
    input  logic [NCH-1:0]      pad_y_i,
    output logic [NCH-1:0]      pad_a_o,
    output logic [NCH-1:0]      pad_oe_o,
    output logic [NCH-1:0]      pad_ie_o,
    output logic [NCH-1:0]      pad_pu_o,
    output logic [NCH-1:0]      pad_pd_o,
    output logic [NCH-1:0]      pad_cs_o,
    output logic [NCH-1:0]      pad_sl_o,
    output logic [NCH-1:0]      pad_pdrv0_o,
    output logic [NCH-1:0]      pad_pdrv1_o,
    output logic                irq_o
);

    localparam logic [3:0] A_OUT   = 4'd0;
    localparam logic [3:0] A_OE    = 4'd1;
    localparam logic [3:0] A_IE    = 4'd2;
    localparam logic [3:0] A_PU    = 4'd3;
    localparam logic [3:0] A_PD    = 4'd4;
    localparam logic [3:0] A_CS    = 4'd5;
    localparam logic [3:0] A_SL    = 4'd6;
    localparam logic [3:0] A_DRV0  = 4'd7;
    localparam logic [3:0] A_DRV1  = 4'd8;
    localparam logic [3:0] A_IN    = 4'd9;
    localparam logic [3:0] A_PEND  = 4'd10;
    localparam logic [3:0] A_IRQEN = 4'd11;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BREAK = 2'd1,
        ST_APPLY = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [NCH-1:0] ch_q, ch_d;
    logic [3:0]     sh_addr_q, sh_addr_d;
    logic [NCH-1:0] sh_data_q, sh_data_d;

    logic [NCH-1:0] out_q, out_d;
    logic [NCH-1:0] oe_q, oe_d;
    logic [NCH-1:0] ie_q, ie_d;
    logic [NCH-1:0] pu_q, pu_d;
    logic [NCH-1:0] pd_q, pd_d;
    logic [NCH-1:0] cs_q, cs_d;
    logic [NCH-1:0] sl_q, sl_d;
    logic [NCH-1:0] drv0_q, drv0_d;
    logic [NCH-1:0] drv1_q, drv1_d;
    logic [NCH-1:0] irq_en_q, irq_en_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic           irq_q, irq_d;
    logic [NCH-1:0] rdata_q, rdata_d;

    logic [SYNC_STAGES-1:0][NCH-1:0] sync_q, sync_d;
    logic [NCH-1:0] in_prev_q, in_prev_d;

    logic           ready;
    logic           acc, wr_acc, rd_acc;
    logic           is_elec;
    logic           commit;
    logic [NCH-1:0] cur_elec;
    logic [NCH-1:0] new_ch;
    logic [NCH-1:0] w1c;
    logic [NCH-1:0] in_val;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] rd_val;

    assign ready  = (state_q == ST_IDLE);
    assign acc    = reg_if.valid & ready;
    assign wr_acc = acc & reg_if.we;
    assign rd_acc = acc & ~reg_if.we;

    assign is_elec = (reg_if.addr >= A_CS) && (reg_if.addr <= A_DRV1);

    always_comb begin
        cur_elec = '0;
        case (reg_if.addr)
            A_CS:    cur_elec = cs_q;
            A_SL:    cur_elec = sl_q;
            A_DRV0:  cur_elec = drv0_q;
            A_DRV1:  cur_elec = drv1_q;
            default: cur_elec = '0;
        endcase
    end

    assign new_ch = reg_if.wdata ^ cur_elec;

    // IE gates the live value so clearing IE drops IN at once without an edge.
    assign in_val = sync_q[SYNC_STAGES-1] & ie_q;
    assign rise   = in_val & ~in_prev_q;

    // Reconfiguration sequencer; a write that changes nothing never leaves IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        sh_addr_d = sh_addr_q;
        sh_data_d = sh_data_q;
        commit    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_acc && is_elec && (new_ch != '0)) begin
                    state_d   = ST_BREAK;
                    cnt_d     = '0;
                    ch_d      = new_ch;
                    sh_addr_d = reg_if.addr;
                    sh_data_d = reg_if.wdata;
                end
            end
            ST_BREAK: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_APPLY;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
                ch_d    = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        out_d    = out_q;
        oe_d     = oe_q;
        ie_d     = ie_q;
        pu_d     = pu_q;
        pd_d     = pd_q;
        cs_d     = cs_q;
        sl_d     = sl_q;
        drv0_d   = drv0_q;
        drv1_d   = drv1_q;
        irq_en_d = irq_en_q;
        w1c      = '0;
        if (wr_acc) begin
            case (reg_if.addr)
                A_OUT:   out_d    = reg_if.wdata;
                A_OE:    oe_d     = reg_if.wdata;
                A_IE:    ie_d     = reg_if.wdata;
                A_PU:    pu_d     = reg_if.wdata;
                A_PD:    pd_d     = reg_if.wdata;
                A_PEND:  w1c      = reg_if.wdata;
                A_IRQEN: irq_en_d = reg_if.wdata;
                default: ;
            endcase
        end
        if (commit) begin
            case (sh_addr_q)
                A_CS:    cs_d   = sh_data_q;
                A_SL:    sl_d   = sh_data_q;
                A_DRV0:  drv0_d = sh_data_q;
                A_DRV1:  drv1_d = sh_data_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (reg_if.addr)
            A_OUT:   rd_val = out_q;
            A_OE:    rd_val = oe_q;
            A_IE:    rd_val = ie_q;
            A_PU:    rd_val = pu_q;
            A_PD:    rd_val = pd_q;
            A_CS:    rd_val = cs_q;
            A_SL:    rd_val = sl_q;
            A_DRV0:  rd_val = drv0_q;
            A_DRV1:  rd_val = drv1_q;
            A_IN:    rd_val = in_val;
            A_PEND:  rd_val = pend_q;
            A_IRQEN: rd_val = irq_en_q;
            default: rd_val = '0;
        endcase
    end

    // A new edge in the same cycle as its W1C keeps the bit set.
    assign pend_d    = (pend_q & ~w1c) | rise;
    assign irq_d     = |(pend_q & irq_en_q);
    assign rdata_d   = rd_acc ? rd_val : rdata_q;
    assign sync_d    = {sync_q[SYNC_STAGES-2:0], pad_y_i & ie_q};
    assign in_prev_d = in_val;

    always_ff @(posedge clk_i) begin
        if (!rn_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ch_q      <= '0;
            sh_addr_q <= '0;
            sh_data_q <= '0;
            out_q     <= '0;
            oe_q      <= '0;
            ie_q      <= '0;
            pu_q      <= '0;
            pd_q      <= '0;
            cs_q      <= '0;
            sl_q      <= '0;
            drv0_q    <= '0;
            drv1_q    <= '0;
            irq_en_q  <= '0;
            pend_q    <= '0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
            sync_q    <= '0;
            in_prev_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            sh_addr_q <= sh_addr_d;
            sh_data_q <= sh_data_d;
            out_q     <= out_d;
            oe_q      <= oe_d;
            ie_q      <= ie_d;
            pu_q      <= pu_d;
            pd_q      <= pd_d;
            cs_q      <= cs_d;
            sl_q      <= sl_d;
            drv0_q    <= drv0_d;
            drv1_q    <= drv1_d;
            irq_en_q  <= irq_en_d;
            pend_q    <= pend_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
            sync_q    <= sync_d;
            in_prev_q <= in_prev_d;
        end
    end

    // Only the channels being reconfigured lose their driver during BREAK.
    assign pad_oe_o    = (state_q == ST_BREAK) ? (oe_q & ~ch_q) : oe_q;
    assign pad_a_o     = out_q;
    assign pad_ie_o    = ie_q;
    assign pad_pu_o    = pu_q & ~pd_q;
    assign pad_pd_o    = pd_q;
    assign pad_cs_o    = cs_q;
    assign pad_sl_o    = sl_q;
    assign pad_pdrv0_o = drv0_q;
    assign pad_pdrv1_o = drv1_q;
    assign irq_o       = irq_q;

    assign reg_if.ready = ready;
    assign reg_if.rdata = rdata_q;

endmodule
